// File: rtl/image_streamer.sv
// image_streamer
//   Transmit side of the pixel stream feeding the 3x3 filter kernel. Walks an
//   OW x OH output raster (frame plus optional zero border). It reads interior
//   pixels from a synchronous-read RAM and emits one pixel per slot on data_o.
//   Each pixel is qualified by a one-cycle done_o strobe.
//
//   Ports
//     clk, rst        clock (rising edge), async active-high reset
//     start           launch one frame (only looked at while idle)
//     abort           drop the current frame on the next edge
//     mem_en/addr     RAM read request; mem_rdata returns one cycle later
//     data_o/done_o   pixel + strobe (data_o holds between strobes)
//     busy            frame in progress
//     frame_done      pulse alongside the final done_o of a frame
//
//   Pipeline: slot issue -> [1] RAM request + tag -> [2] RAM latency -> [3] output.
//   r_vld_pipe[k] is the valid bit of stage k; stage 3 valid is done_o itself.
module image_streamer #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16,
  parameter int PAD    = 1,
  parameter int GAP    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        data_o,
  output logic              done_o,
  output logic              busy,
  output logic              frame_done
);

  localparam int OW   = IMG_W + 2*PAD;
  localparam int OH   = IMG_H + 2*PAD;
  localparam int MAXD = (OW > OH) ? OW : OH;
  localparam int CW   = $clog2(MAXD + 1);
  localparam logic [CW-1:0] OW_M1 = CW'(OW - 1);
  localparam logic [CW-1:0] OH_M1 = CW'(OH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  // Per-slot side information travelling alongside the RAM access.
  typedef struct packed {
    logic pad;   // border slot: emit zero instead of RAM data
    logic last;  // final slot of the frame
  } tag_t;

  state_t            r_state;
  logic [CW-1:0]     r_row, r_col;
  logic [3:0]        r_gap;
  logic [ADDR_W-1:0] r_raddr;
  logic [3:1]        r_vld_pipe;
  tag_t [2:1]        r_tag;

  logic w_issue, w_last, w_int;

  // A slot is issued in RUN whenever the inter-slot gap counter has expired.
  assign w_issue = (r_state == S_RUN) && (r_gap == 4'd0);
  assign w_last  = (r_row == OH_M1) && (r_col == OW_M1);
  // With a one-pixel border, the border is exactly the first/last row and column.
  assign w_int   = (PAD == 0) ||
                   ((r_row != '0) && (r_row != OH_M1) &&
                    (r_col != '0) && (r_col != OW_M1));

  assign done_o = r_vld_pipe[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_gap      <= '0;
      r_raddr    <= '0;
      r_vld_pipe <= '0;
      r_tag      <= '0;
      mem_en     <= 1'b0;
      mem_addr   <= '0;
      data_o     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      if (abort && (r_state != S_IDLE)) begin
        // Flush: in-flight slots are dropped, nothing more is emitted.
        r_state    <= S_IDLE;
        busy       <= 1'b0;
        r_vld_pipe <= '0;
        frame_done <= 1'b0;
      end else begin
        r_vld_pipe <= {r_vld_pipe[2:1], w_issue};
        r_tag[2]   <= r_tag[1];
        frame_done <= r_vld_pipe[2] & r_tag[2].last;
        if (r_vld_pipe[2])
          data_o <= r_tag[2].pad ? 8'd0 : mem_rdata;

        unique case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state <= S_RUN;
              busy    <= 1'b1;
              r_row   <= '0;
              r_col   <= '0;
              r_gap   <= '0;
              r_raddr <= '0;
            end
          end
          S_RUN: begin
            if (w_issue) begin
              r_gap         <= 4'(GAP);
              r_tag[1].pad  <= ~w_int;
              r_tag[1].last <= w_last;
              // Interior pixels are visited in raster order, so the RAM
              // address is a plain running count of interior slots.
              if (w_int) begin
                mem_en   <= 1'b1;
                mem_addr <= r_raddr;
                r_raddr  <= r_raddr + ADDR_W'(1);
              end
              if (w_last) begin
                r_state <= S_DRAIN;
              end else if (r_col == OW_M1) begin
                r_col <= '0;
                r_row <= r_row + CW'(1);
              end else begin
                r_col <= r_col + CW'(1);
              end
            end else begin
              r_gap <= r_gap - 4'd1;
            end
          end
          S_DRAIN: begin
            // frame_done marks the final strobe; busy drops on the next edge.
            if (frame_done) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_image_streamer.sv
// Directed bench for image_streamer. Three instances run a 4x3 frame:
//   0: PAD=1 GAP=0, 1: PAD=0 GAP=0, 2: PAD=1 GAP=2. Each has a RAM holding RAM[a]=a+1.
module tb_image_streamer;

  logic clk = 1'b0;
  logic rst;
  logic [2:0]       st, ab, men, done, busy, fdone;
  logic [2:0][15:0] addr;
  logic [2:0][7:0]  rd, data;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM models, contents RAM[a] = a+1.
  always @(posedge clk) begin
    if (men[0]) rd[0] <= addr[0][7:0] + 8'd1;
    if (men[1]) rd[1] <= addr[1][7:0] + 8'd1;
    if (men[2]) rd[2] <= addr[2][7:0] + 8'd1;
  end

  image_streamer #(.IMG_W(4), .IMG_H(3), .ADDR_W(16), .PAD(1), .GAP(0)) u_a (
    .clk(clk), .rst(rst), .start(st[0]), .abort(ab[0]), .mem_en(men[0]),
    .mem_addr(addr[0]), .mem_rdata(rd[0]), .data_o(data[0]), .done_o(done[0]),
    .busy(busy[0]), .frame_done(fdone[0]));

  image_streamer #(.IMG_W(4), .IMG_H(3), .ADDR_W(16), .PAD(0), .GAP(0)) u_b (
    .clk(clk), .rst(rst), .start(st[1]), .abort(ab[1]), .mem_en(men[1]),
    .mem_addr(addr[1]), .mem_rdata(rd[1]), .data_o(data[1]), .done_o(done[1]),
    .busy(busy[1]), .frame_done(fdone[1]));

  image_streamer #(.IMG_W(4), .IMG_H(3), .ADDR_W(16), .PAD(1), .GAP(2)) u_c (
    .clk(clk), .rst(rst), .start(st[2]), .abort(ab[2]), .mem_en(men[2]),
    .mem_addr(addr[2]), .mem_rdata(rd[2]), .data_o(data[2]), .done_o(done[2]),
    .busy(busy[2]), .frame_done(fdone[2]));

  int ntot = 0, npass = 0, nfail = 0;
  int cap_d[64], cap_t[64], maddr[64];
  int ncap, nfd, nmem, fd_t, busy_drop;
  int s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected pixel for output slot i of the padded 6x5 raster.
  function automatic int exp_pix(input int i);
    int r, c;
    r = i / 6;
    c = i % 6;
    if (r >= 1 && r <= 3 && c >= 1 && c <= 4) return (r - 1) * 4 + c;
    return 0;
  endfunction

  // Start a frame on instance d; s = cycle stamp of the negedge after start is sampled.
  task automatic go(input int d, input logic with_abort, output int s_o);
    @(negedge clk);
    st[d] = 1'b1;
    ab[d] = with_abort;
    @(negedge clk);
    st[d] = 1'b0;
    ab[d] = 1'b0;
    s_o   = cyc;
    check("busy_after_start", 32'(busy[d]), 1);
  endtask

  // Observe instance d for ncyc negedges. Pulse start after strobe st_at and
  // abort after strobe ab_at (0 = never).
  task automatic collect(input int d, input int ncyc, input int st_at, input int ab_at);
    ncap = 0; nfd = 0; nmem = 0; fd_t = -1; busy_drop = -1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      st[d] = 1'b0;
      ab[d] = 1'b0;
      if (men[d] && nmem < 64) begin maddr[nmem] = int'(addr[d]); nmem++; end
      if (fdone[d]) begin nfd++; fd_t = cyc; end
      if (busy_drop < 0 && ncap > 0 && !busy[d]) busy_drop = cyc;
      if (done[d]) begin
        if (ncap < 64) begin cap_d[ncap] = int'(data[d]); cap_t[ncap] = cyc; end
        ncap++;
        if (ncap == st_at) st[d] = 1'b1;
        if (ncap == ab_at) ab[d] = 1'b1;
      end
    end
  endtask

  task automatic check_pad_frame(input string t, input int s_i, input int gap);
    int bad_sp, bad_ad;
    bad_sp = 0;
    bad_ad = 0;
    check({t, "_count"}, ncap, 30);
    check({t, "_first_latency"}, cap_t[0] - s_i, 3);
    for (int i = 1; i < 30; i++) if (cap_t[i] - cap_t[i-1] != gap + 1) bad_sp++;
    check({t, "_spacing_errors"}, bad_sp, 0);
    for (int i = 0; i < 30; i++) check($sformatf("%s_pix%0d", t, i), cap_d[i], exp_pix(i));
    check({t, "_frame_done_count"}, nfd, 1);
    check({t, "_frame_done_with_last"}, fd_t, cap_t[29]);
    check({t, "_busy_drop"}, busy_drop, cap_t[29] + 1);
    check({t, "_mem_en_count"}, nmem, 12);
    for (int i = 0; i < 12; i++) if (maddr[i] != i) bad_ad++;
    check({t, "_addr_errors"}, bad_ad, 0);
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    st  = '0;
    ab  = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_done",  32'(done[d]),  0);
      check("rst_busy",  32'(busy[d]),  0);
      check("rst_fdone", 32'(fdone[d]), 0);
      check("rst_mem_en", 32'(men[d]),  0);
      check("rst_data",  32'(data[d]),  0);
      check("rst_addr",  32'(addr[d]),  0);
    end
    rst = 1'b0;

    // 1: padded frame, back-to-back slots
    go(0, 1'b0, s);
    collect(0, 40, 0, 0);
    check_pad_frame("t1", s, 0);

    // 2: no border, 12 pixels straight from RAM
    go(1, 1'b0, s);
    collect(1, 25, 0, 0);
    check("t2_count", ncap, 12);
    check("t2_first_latency", cap_t[0] - s, 3);
    bad = 0;
    for (int i = 0; i < 12; i++) if (cap_d[i] != i + 1 || maddr[i] != i) bad++;
    check("t2_data_addr_errors", bad, 0);
    check("t2_consecutive", cap_t[11] - cap_t[0], 11);
    check("t2_mem_en_count", nmem, 12);
    check("t2_frame_done_with_last", fd_t, cap_t[11]);
    check("t2_busy_drop", busy_drop, cap_t[11] + 1);

    // 3: GAP=2, one strobe every third cycle
    go(2, 1'b0, s);
    collect(2, 100, 0, 0);
    check_pad_frame("t3", s, 2);

    // 4: start re-pulsed at pixel 5 while busy is ignored
    go(0, 1'b0, s);
    collect(0, 40, 5, 0);
    check_pad_frame("t4", s, 0);

    // 5: abort on the 10th strobe, then restart with start+abort together
    go(0, 1'b0, s);
    collect(0, 40, 0, 10);
    check("t5_abort_count", ncap, 10);
    check("t5_abort_no_frame_done", nfd, 0);
    check("t5_abort_busy_drop", busy_drop, cap_t[9] + 1);
    go(0, 1'b1, s);
    collect(0, 40, 0, 0);
    check_pad_frame("t5r", s, 0);

    // 6: asynchronous reset in the middle of a frame
    go(0, 1'b0, s);
    repeat (8) @(negedge clk);
    check("t6_pre_busy", 32'(busy[0]), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_done",  32'(done[0]),  0);
    check("t6_rst_busy",  32'(busy[0]),  0);
    check("t6_rst_mem_en", 32'(men[0]),  0);
    check("t6_rst_data",  32'(data[0]),  0);
    check("t6_rst_fdone", 32'(fdone[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    go(0, 1'b0, s);
    collect(0, 40, 0, 0);
    check_pad_frame("t6", s, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
